// File: rtl/dram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single DRAM port.
// Holds Addr/strobes/DataOut for MEM_LAT cycles, then pulses Ack with registered read data.
module dram_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [1:0]        Req,
    input  logic [1:0]        We,
    input  logic [ADDR_W-1:0] ReqAddr0,
    input  logic [ADDR_W-1:0] ReqAddr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic [1:0]        Gnt,
    output logic [1:0]        Ack,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn
);

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nxt;
    logic              owner, owner_nxt;
    logic              rr_ptr, rr_nxt;
    logic [3:0]        lat_cnt, lat_nxt;
    logic [1:0]        gnt_nxt, ack_nxt;
    logic [DATA_W-1:0] rdata_nxt, dout_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              rd_nxt, wr_nxt;
    logic              sel;
    logic              last;

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            lat_cnt <= 4'd0;
            Gnt     <= 2'b00;
            Ack     <= 2'b00;
            RData   <= '0;
            Addr    <= '0;
            RD      <= 1'b0;
            WR      <= 1'b0;
            DataOut <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_nxt;
            lat_cnt <= lat_nxt;
            Gnt     <= gnt_nxt;
            Ack     <= ack_nxt;
            RData   <= rdata_nxt;
            Addr    <= addr_nxt;
            RD      <= rd_nxt;
            WR      <= wr_nxt;
            DataOut <= dout_nxt;
        end
    end

    // A lone requester wins outright; contention is settled by rr_ptr.
    always_comb begin
        state_nxt = state;
        last      = (lat_cnt == LAST);
        sel       = rr_ptr;
        if (Req == 2'b01)
            sel = 1'b0;
        else if (Req == 2'b10)
            sel = 1'b1;
        case (state)
            IDLE:    if (|Req) state_nxt = ACCESS;
            ACCESS:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        lat_nxt   = lat_cnt;
        gnt_nxt   = 2'b00;
        ack_nxt   = 2'b00;
        rdata_nxt = RData;
        addr_nxt  = Addr;
        dout_nxt  = DataOut;
        rd_nxt    = RD;
        wr_nxt    = WR;
        case (state)
            IDLE: begin
                if (|Req) begin
                    owner_nxt = sel;
                    rr_nxt    = ~sel;
                    lat_nxt   = 4'd0;
                    gnt_nxt   = sel ? 2'b10 : 2'b01;
                    addr_nxt  = sel ? ReqAddr1 : ReqAddr0;
                    dout_nxt  = sel ? WData1 : WData0;
                    wr_nxt    = We[sel];
                    rd_nxt    = ~We[sel];
                end
            end
            ACCESS: begin
                if (last) begin
                    rd_nxt  = 1'b0;
                    wr_nxt  = 1'b0;
                    ack_nxt = owner ? 2'b10 : 2'b01;
                    if (RD)
                        rdata_nxt = DataIn;
                end else begin
                    lat_nxt = lat_cnt + 4'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter (MEM_LAT=2) with a small DRAM model.
module tb_dram_port_arbiter;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [1:0]  Req, We;
    logic [15:0] ReqAddr0, ReqAddr1, WData0, WData1;
    logic [1:0]  Gnt, Ack;
    logic [15:0] RData, Addr, DataOut, DataIn;
    logic        RD, WR;

    logic [15:0] mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    always #5 Clk1 = ~Clk1;

    dram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .Clk1(Clk1), .Reset(Reset), .Req(Req), .We(We),
        .ReqAddr0(ReqAddr0), .ReqAddr1(ReqAddr1), .WData0(WData0), .WData1(WData1),
        .Gnt(Gnt), .Ack(Ack), .RData(RData), .Addr(Addr), .RD(RD), .WR(WR),
        .DataOut(DataOut), .DataIn(DataIn)
    );

    // DRAM model: preloaded while Reset is high, written on edges where WR is high.
    always @(posedge Clk1) begin
        if (Reset) begin
            mem[8'h10] = 16'hBEEF;
            mem[8'h30] = 16'hC0DE;
            mem[8'hFF] = 16'h5A5A;
        end else if (WR) begin
            mem[Addr[7:0]] = DataOut;
        end
    end
    assign DataIn = mem[Addr[7:0]];

    task automatic tick;
        @(posedge Clk1);
        #1;
    endtask

    task automatic apply_reset;
        Reset = 1'b1;
        tick;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Req = 2'b00; We = 2'b00; ReqAddr0 = '0; ReqAddr1 = '0; WData0 = '0; WData1 = '0;
        Reset = 1'b1;
        #1;
        vectors++; if (Gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", Gnt); end
        vectors++; if (Ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack got %b want 00", Ack); end
        vectors++; if ({RD, WR} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes got %b want 00", {RD, WR}); end
        vectors++; if (Addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0000", Addr); end
        vectors++; if (DataOut !== 16'h0) begin miscompares++; $display("FAIL reset_dataout got %h want 0000", DataOut); end
        vectors++; if (RData !== 16'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", RData); end
        tick;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_read;
        Req = 2'b01; We = 2'b00; ReqAddr0 = 16'h0010;
        tick;
        vectors++; if (Gnt !== 2'b01) begin miscompares++; $display("FAIL rd_gnt got %b want 01", Gnt); end
        vectors++; if ({RD, WR} !== 2'b10) begin miscompares++; $display("FAIL rd_c1_strobes got %b want 10", {RD, WR}); end
        vectors++; if (Addr !== 16'h0010) begin miscompares++; $display("FAIL rd_c1_addr got %h want 0010", Addr); end
        Req = 2'b00;
        tick;
        vectors++; if ({RD, WR, Gnt, Ack} !== 6'b10_00_00) begin miscompares++; $display("FAIL rd_c2 got RD/WR/Gnt/Ack %b want 100000", {RD, WR, Gnt, Ack}); end
        vectors++; if (Addr !== 16'h0010) begin miscompares++; $display("FAIL rd_c2_addr got %h want 0010", Addr); end
        tick;
        vectors++; if (Ack !== 2'b01) begin miscompares++; $display("FAIL rd_ack got %b want 01", Ack); end
        vectors++; if (RData !== 16'hBEEF) begin miscompares++; $display("FAIL rd_rdata got %h want beef", RData); end
        vectors++; if ({RD, WR} !== 2'b00) begin miscompares++; $display("FAIL rd_c3_strobes got %b want 00", {RD, WR}); end
    endtask

    task automatic test_write;
        Req = 2'b10; We = 2'b10; ReqAddr1 = 16'h0020; WData1 = 16'h1234;
        tick;
        vectors++; if (Gnt !== 2'b10) begin miscompares++; $display("FAIL wr_gnt got %b want 10", Gnt); end
        vectors++; if ({RD, WR} !== 2'b01) begin miscompares++; $display("FAIL wr_c1_strobes got %b want 01", {RD, WR}); end
        vectors++; if (DataOut !== 16'h1234) begin miscompares++; $display("FAIL wr_dataout got %h want 1234", DataOut); end
        Req = 2'b00; We = 2'b00;
        tick;
        vectors++; if ({RD, WR} !== 2'b01) begin miscompares++; $display("FAIL wr_c2_strobes got %b want 01", {RD, WR}); end
        vectors++; if (Addr !== 16'h0020) begin miscompares++; $display("FAIL wr_c2_addr got %h want 0020", Addr); end
        tick;
        vectors++; if (Ack !== 2'b10) begin miscompares++; $display("FAIL wr_ack got %b want 10", Ack); end
        vectors++; if ({RD, WR} !== 2'b00) begin miscompares++; $display("FAIL wr_c3_strobes got %b want 00", {RD, WR}); end
        vectors++; if (RData !== 16'hBEEF) begin miscompares++; $display("FAIL wr_rdata_kept got %h want beef", RData); end
        Req = 2'b01; ReqAddr0 = 16'h0020;
        tick;
        vectors++; if (Gnt !== 2'b01) begin miscompares++; $display("FAIL rb_gnt got %b want 01", Gnt); end
        Req = 2'b00;
        tick;
        tick;
        vectors++; if (Ack !== 2'b01) begin miscompares++; $display("FAIL rb_ack got %b want 01", Ack); end
        vectors++; if (RData !== 16'h1234) begin miscompares++; $display("FAIL rb_rdata got %h want 1234", RData); end
    endtask

    task automatic test_round_robin;
        logic [1:0]  eg, ea;
        logic [15:0] ed;
        int acks;
        acks = 0;
        Reset = 1'b1;
        Req = 2'b11; We = 2'b00; ReqAddr0 = 16'h0010; ReqAddr1 = 16'h0030;
        tick;
        Reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            eg = 2'b00; ea = 2'b00;
            if (c % 3 == 1) eg = (((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (c % 3 == 0) ea = (((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
            if (Ack != 2'b00) acks++;
            vectors++; if (Gnt !== eg) begin miscompares++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, Gnt, eg); end
            vectors++; if (Ack !== ea) begin miscompares++; $display("FAIL rr_ack cycle %0d got %b want %b", c, Ack, ea); end
            vectors++; if ($countones(Gnt | Ack) > 1) begin miscompares++; $display("FAIL rr_onehot cycle %0d got Gnt=%b Ack=%b want at most one bit", c, Gnt, Ack); end
            if (ea != 2'b00) begin
                ed = (ea == 2'b01) ? 16'hBEEF : 16'hC0DE;
                vectors++; if (RData !== ed) begin miscompares++; $display("FAIL rr_rdata cycle %0d got %h want %h", c, RData, ed); end
            end
        end
        Req = 2'b00;
        vectors++; if (acks !== 4) begin miscompares++; $display("FAIL rr_ack_count got %0d want 4", acks); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] eg, ea;
        logic       erd;
        apply_reset;
        Req = 2'b01; We = 2'b00; ReqAddr0 = 16'h0010;
        for (int c = 1; c <= 9; c++) begin
            tick;
            eg  = (c % 3 == 1) ? 2'b01 : 2'b00;
            ea  = (c % 3 == 0) ? 2'b01 : 2'b00;
            erd = (c % 3 != 0);
            vectors++; if (Gnt !== eg) begin miscompares++; $display("FAIL b2b_gnt cycle %0d got %b want %b", c, Gnt, eg); end
            vectors++; if (Ack !== ea) begin miscompares++; $display("FAIL b2b_ack cycle %0d got %b want %b", c, Ack, ea); end
            vectors++; if (RD !== erd) begin miscompares++; $display("FAIL b2b_rd cycle %0d got %b want %b", c, RD, erd); end
        end
        Req = 2'b00;
        tick;
    endtask

    task automatic test_reset_mid_access;
        Req = 2'b01; We = 2'b00; ReqAddr0 = 16'h0010; ReqAddr1 = 16'h0030;
        tick;
        vectors++; if ({Gnt, RD} !== 3'b01_1) begin miscompares++; $display("FAIL mid_start got Gnt/RD %b want 011", {Gnt, RD}); end
        #2 Reset = 1'b1;
        #1;
        vectors++; if ({RD, WR} !== 2'b00) begin miscompares++; $display("FAIL mid_strobes got %b want 00", {RD, WR}); end
        vectors++; if (Addr !== 16'h0) begin miscompares++; $display("FAIL mid_addr got %h want 0000", Addr); end
        vectors++; if (Gnt !== 2'b00) begin miscompares++; $display("FAIL mid_gnt got %b want 00", Gnt); end
        Req = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick;
            vectors++; if (Ack !== 2'b00) begin miscompares++; $display("FAIL mid_no_ack step %0d got %b want 00", c, Ack); end
        end
        Reset = 1'b0;
        tick;
        vectors++; if (Gnt !== 2'b01) begin miscompares++; $display("FAIL mid_regrant got %b want 01", Gnt); end
        vectors++; if (Ack !== 2'b00) begin miscompares++; $display("FAIL mid_regrant_ack got %b want 00", Ack); end
        Req = 2'b00;
        tick;
        tick;
        vectors++; if (Ack !== 2'b01) begin miscompares++; $display("FAIL mid_ack got %b want 01", Ack); end
        vectors++; if (RData !== 16'hBEEF) begin miscompares++; $display("FAIL mid_rdata got %h want beef", RData); end
    endtask

    task automatic test_max_addr;
        Req = 2'b10; We = 2'b00; ReqAddr1 = 16'hFFFF;
        tick;
        vectors++; if (Gnt !== 2'b10) begin miscompares++; $display("FAIL max_gnt got %b want 10", Gnt); end
        vectors++; if (Addr !== 16'hFFFF) begin miscompares++; $display("FAIL max_addr got %h want ffff", Addr); end
        vectors++; if (RD !== 1'b1) begin miscompares++; $display("FAIL max_rd got %b want 1", RD); end
        Req = 2'b00;
        tick;
        tick;
        vectors++; if (Ack !== 2'b10) begin miscompares++; $display("FAIL max_ack got %b want 10", Ack); end
        vectors++; if (RData !== 16'h5A5A) begin miscompares++; $display("FAIL max_rdata got %h want 5a5a", RData); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_round_robin;
        test_back_to_back;
        test_reset_mid_access;
        test_max_addr;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Shares the single DRAM port (Addr/DataIn/DataOut/RD/WR) between two requesters: requester 0 is the CVP14 core and requester 1 is a DMA/memory-dump engine. Round-robin arbitration runs over a simple req/gnt/ack handshake. The arbiter holds Addr, RD/WR and DataOut stable for a fixed number of DRAM access cycles, then returns read data with a one-cycle ack. It sits between the requesters and the DRAM model, in place of the direct core-to-DRAM connection.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 2, cycles RD/WR is held asserted per access; DataIn is valid in the last of them (legal range 1..15)

Ports:
Clk1  in  1  single system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req  in  2  per-requester request; bit 0 = core, bit 1 = DMA
We  in  2  per-requester write enable, qualified by Req
ReqAddr0  in  ADDR_W  requester 0 address
ReqAddr1  in  ADDR_W  requester 1 address
WData0  in  DATA_W  requester 0 write data
WData1  in  DATA_W  requester 1 write data
Gnt  out  2  one-hot one-cycle pulse: request accepted
Ack  out  2  one-hot one-cycle pulse: access complete, RData valid
RData  out  DATA_W  read data, shared by both requesters
Addr  out  ADDR_W  DRAM address
RD  out  1  DRAM read strobe
WR  out  1  DRAM write strobe
DataOut  out  DATA_W  DRAM write data
DataIn  in  DATA_W  DRAM read data

Behaviour:
- Reset (async, any time): state=IDLE, Gnt=0, Ack=0, RData=0, Addr=0, RD=0, WR=0, DataOut=0, lat_cnt=0, rr_ptr=0 (requester 0 favoured). Reset mid-access abandons the access: no Ack, strobes drop immediately.
- All outputs are registered.
- States: IDLE, ACCESS.
- IDLE, Req==0: stay; all strobes 0.
- IDLE, exactly one Req bit set: grant that requester.
- IDLE, both Req bits set: grant requester rr_ptr.
- On grant to requester i (next edge):
  - Gnt[i]=1 for one cycle.
  - Latch Addr=ReqAddr_i and DataOut=WData_i.
  - RD = ~We[i], WR = We[i].
  - lat_cnt=0; rr_ptr = ~i; state=ACCESS.
- ACCESS:
  - Addr, DataOut, RD/WR held constant.
  - lat_cnt increments each cycle.
  - When lat_cnt == MEM_LAT-1, on that edge:
    - RD=WR=0.
    - RData=DataIn on a read; RData unchanged on a write.
    - Ack[i]=1 for one cycle; state=IDLE.
- Timing:
  - Grant edge = cycle 1. Strobe high for cycles 1..MEM_LAT. Ack in cycle MEM_LAT+1.
  - The arbiter is in IDLE during the Ack cycle and may grant a new request on that edge, so back-to-back throughput is one access per MEM_LAT+1 cycles. RD/WR deassert for at least one cycle between accesses.
- Requester rules:
  - Hold Req, We, address and data stable until Gnt is seen.
  - Drop Req in the cycle after Gnt, unless issuing another access.
  - Req still high in the Ack cycle is a new request.
- Req changes during ACCESS are ignored; pending requests are evaluated only in IDLE.
- A single requester with no competition may be granted consecutively; rr_ptr still toggles to the other requester after each grant.
- Gnt and Ack are never both set for different requesters in the same cycle. Gnt and Ack never assert in the same cycle for the same access.
- Addresses pass through unmodified, including 16'hFFFF; no wrap or decode.

Test Plan:
1. MEM_LAT=2, Req=01, We=00, ReqAddr0=0x0010, DRAM[0x0010]=0xBEEF -> Gnt=01 cycle 1; RD=1 with Addr=0x0010 cycles 1–2; Ack=01 and RData=0xBEEF cycle 3; WR=0 throughout.
2. Req=10, We=10, ReqAddr1=0x0020, WData1=0x1234 -> WR=1, DataOut=0x1234 for 2 cycles; Ack=10; then a read by requester 0 of 0x0020 returns 0x1234.
3. Req=11 held continuously after reset -> grants alternate 01,10,01,10; 4 Acks within 12 cycles; Gnt/Ack always one-hot.
4. Req=01 held, Req[1]=0 -> requester 0 granted every 3 cycles; RD low for exactly one cycle between accesses.
5. Reset asserted in cycle 1 of an access -> RD/WR/Addr go to 0 immediately with no clock edge; no Ack; after release, the first grant with Req=11 goes to requester 0.
6. Req=10 with ReqAddr1=0xFFFF, read -> Addr=0xFFFF on the port; normal Ack.
